// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller: digit count,
// FSM state encoding and the hex-to-segment pattern table.
package seg_pkg;

  localparam int N_DIGITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  // Segment patterns {g,f,e,d,c,b,a}; element 0 is hex 0, element 15 is hex F.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational 4-bit hex code to active-high 7-segment pattern lookup.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 8-digit seven-segment scanner with a blanking gap per slot and
// double-buffered frame loading that only commits on frame boundaries.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 1000,
  parameter int DEAD    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                load_valid,
  input  logic [31:0]         load_data,
  output logic                load_ready,
  input  logic [N_DIGITS-1:0] blank_mask,
  input  logic [N_DIGITS-1:0] dp_mask,
  output logic [N_DIGITS-1:0] COM,
  output logic [6:0]          seg,
  output logic                dp,
  output logic                frame_tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(CLK_DIV - 1);
  localparam logic [N_DIGITS-1:0] ONE_HOT0 = N_DIGITS'(1);

  state_t        state_reg;
  logic [2:0]    idx_reg;
  logic [CW-1:0] cnt_reg;
  logic [31:0]   active_reg;
  logic [31:0]   pending_reg;
  logic          pending_full_reg;

  logic [3:0]    cur_hex;
  logic [6:0]    cur_seg;
  logic          frame_end;
  logic          commit;

  assign cur_hex = active_reg[{idx_reg, 2'b00} +: 4];

  seg_hex_decoder u_dec (
    .hex (cur_hex),
    .seg (cur_seg)
  );

  // Leaving slot 7 of SHOW is the only in-scan point where a new frame may land.
  assign frame_end = (state_reg == SHOW) && en && (cnt_reg == SLOT_LAST) && (idx_reg == 3'd7);
  assign commit    = (state_reg == IDLE) || frame_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      idx_reg          <= 3'd0;
      cnt_reg          <= '0;
      active_reg       <= 32'd0;
      pending_reg      <= 32'd0;
      pending_full_reg <= 1'b0;
      load_ready       <= 1'b1;
      COM              <= '1;
      seg              <= 7'd0;
      dp               <= 1'b0;
      frame_tick       <= 1'b0;
    end else begin
      frame_tick <= frame_end;

      // load_ready mirrors !pending_full, so accept and commit are exclusive.
      if (commit && pending_full_reg) begin
        active_reg       <= pending_reg;
        pending_full_reg <= 1'b0;
        load_ready       <= 1'b1;
      end else if (load_valid && load_ready) begin
        pending_reg      <= load_data;
        pending_full_reg <= 1'b1;
        load_ready       <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          idx_reg <= 3'd0;
          COM     <= '1;
          seg     <= 7'd0;
          dp      <= 1'b0;
          if (en) state_reg <= BLANK;
        end
        BLANK: begin
          if (!en) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= 3'd0;
          end else if (cnt_reg == DEAD_LAST) begin
            state_reg <= SHOW;
            cnt_reg   <= cnt_reg + 1'b1;
            COM       <= ~(ONE_HOT0 << idx_reg);
            seg       <= blank_mask[idx_reg] ? 7'd0 : cur_seg;
            dp        <= blank_mask[idx_reg] ? 1'b0 : dp_mask[idx_reg];
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
          if (!en || cnt_reg != DEAD_LAST) begin
            COM <= '1;
            seg <= 7'd0;
            dp  <= 1'b0;
          end
        end
        SHOW: begin
          if (!en || cnt_reg == SLOT_LAST) begin
            state_reg <= en ? BLANK : IDLE;
            cnt_reg   <= '0;
            idx_reg   <= en ? idx_reg + 3'd1 : 3'd0;
            COM       <= '1;
            seg       <= 7'd0;
            dp        <= 1'b0;
          end else begin
            // Refresh every cycle so mask changes take effect mid-slot.
            cnt_reg <= cnt_reg + 1'b1;
            COM     <= ~(ONE_HOT0 << idx_reg);
            seg     <= blank_mask[idx_reg] ? 7'd0 : cur_seg;
            dp      <= blank_mask[idx_reg] ? 1'b0 : dp_mask[idx_reg];
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          idx_reg   <= 3'd0;
          COM       <= '1;
          seg       <= 7'd0;
          dp        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with CLK_DIV=8, DEAD=2; outputs sampled on
// the falling edge, inputs driven on the falling edge.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = 32'd0;
  logic        load_ready;
  logic [7:0]  blank_mask = 8'd0;
  logic [7:0]  dp_mask = 8'd0;
  logic [7:0]  COM;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int checks = 0;
  int passed = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg_scan_ctrl #(.CLK_DIV(8), .DEAD(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .blank_mask (blank_mask),
    .dp_mask    (dp_mask),
    .COM        (COM),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Expected {COM, seg, dp} for the i-th sample after en rose (i starts at 1).
  function automatic logic [15:0] exp_out(input int i, input logic [31:0] data,
                                          input logic [7:0] bm, input logic [7:0] dm);
    int         s;
    int         pos;
    logic [3:0] h;
    logic [7:0] one;
    one = 8'd1;
    s   = ((i - 1) / 8) % 8;
    pos = (i - 1) % 8;
    if (pos < 2) return {8'hFF, 7'h00, 1'b0};
    h = data[s*4 +: 4];
    return {~(one << s), bm[s] ? 7'h00 : seg_tab[h], bm[s] ? 1'b0 : dm[s]};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (COM !== 8'hFF) $display("FAIL reset_com got %h want ff", COM); else passed++;
    checks++; if (seg !== 7'h00) $display("FAIL reset_seg got %h want 00", seg); else passed++;
    checks++; if (dp !== 1'b0) $display("FAIL reset_dp got %b want 0", dp); else passed++;
    checks++; if (frame_tick !== 1'b0) $display("FAIL reset_tick got %b want 0", frame_tick); else passed++;
    checks++; if (load_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", load_ready); else passed++;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (COM !== 8'hFF) $display("FAIL idle_com got %h want ff", COM); else passed++;
    $display("test_reset done");
  endtask

  task automatic test_scan_timing();
    logic [7:0] want;
    en = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      want = (i <= 2) ? 8'hFF : (i <= 8) ? 8'hFE : (i <= 10) ? 8'hFF : 8'hFD;
      checks++; if (COM !== want) $display("FAIL timing_com i=%0d got %h want %h", i, COM, want); else passed++;
      if (i >= 3 && i <= 8) begin
        checks++; if (seg !== 7'h3F) $display("FAIL timing_seg i=%0d got %h want 3f", i, seg); else passed++;
      end
    end
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("test_scan_timing done");
  endtask

  task automatic test_frame_load();
    logic [15:0] e;
    logic        want_tick;
    load_valid = 1'b1;
    load_data  = 32'h76543210;
    @(negedge clk);
    checks++; if (load_ready !== 1'b0) $display("FAIL load_accept got %b want 0", load_ready); else passed++;
    load_valid = 1'b0;
    @(negedge clk);
    checks++; if (load_ready !== 1'b1) $display("FAIL idle_commit got %b want 1", load_ready); else passed++;
    en = 1'b1;
    for (int i = 1; i <= 130; i++) begin
      @(negedge clk);
      e = exp_out(i, 32'h76543210, 8'h00, 8'h00);
      want_tick = (i == 65) || (i == 129);
      checks++; if (COM !== e[15:8]) $display("FAIL load_com i=%0d got %h want %h", i, COM, e[15:8]); else passed++;
      checks++; if (seg !== e[7:1]) $display("FAIL load_seg i=%0d got %h want %h", i, seg, e[7:1]); else passed++;
      checks++; if (frame_tick !== want_tick) $display("FAIL frame_tick i=%0d got %b want %b", i, frame_tick, want_tick); else passed++;
    end
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("test_frame_load done");
  endtask

  task automatic test_midframe_load();
    logic [15:0] e;
    logic        want_rdy;
    en = 1'b1;
    for (int i = 1; i <= 128; i++) begin
      @(negedge clk);
      e = exp_out(i, (i <= 64) ? 32'h76543210 : 32'hFFFFFFFF, 8'h00, 8'h00);
      want_rdy = (i <= 10) || (i >= 65);
      checks++; if (COM !== e[15:8]) $display("FAIL mid_com i=%0d got %h want %h", i, COM, e[15:8]); else passed++;
      checks++; if (seg !== e[7:1]) $display("FAIL mid_seg i=%0d got %h want %h", i, seg, e[7:1]); else passed++;
      checks++; if (load_ready !== want_rdy) $display("FAIL mid_ready i=%0d got %b want %b", i, load_ready, want_rdy); else passed++;
      if (i == 10) begin
        load_valid = 1'b1;
        load_data  = 32'hFFFFFFFF;
      end
      if (i == 11) load_valid = 1'b0;
    end
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("test_midframe_load done");
  endtask

  task automatic test_ignored_load();
    logic [15:0] e;
    logic        want_rdy;
    en = 1'b1;
    for (int i = 1; i <= 128; i++) begin
      @(negedge clk);
      e = exp_out(i, (i <= 64) ? 32'hFFFFFFFF : 32'h11111111, 8'h00, 8'h00);
      want_rdy = (i <= 3) || (i >= 65);
      checks++; if (seg !== e[7:1]) $display("FAIL ign_seg i=%0d got %h want %h", i, seg, e[7:1]); else passed++;
      checks++; if (load_ready !== want_rdy) $display("FAIL ign_ready i=%0d got %b want %b", i, load_ready, want_rdy); else passed++;
      if (i == 3) begin
        load_valid = 1'b1;
        load_data  = 32'h11111111;
      end
      if (i == 5) load_data = 32'h22222222;
      if (i == 20) load_valid = 1'b0;
    end
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("test_ignored_load done");
  endtask

  task automatic test_masks();
    logic [15:0] e;
    blank_mask = 8'h80;
    dp_mask    = 8'h01;
    en = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      e = exp_out(i, 32'h11111111, 8'h80, 8'h01);
      checks++; if (COM !== e[15:8]) $display("FAIL mask_com i=%0d got %h want %h", i, COM, e[15:8]); else passed++;
      checks++; if (seg !== e[7:1]) $display("FAIL mask_seg i=%0d got %h want %h", i, seg, e[7:1]); else passed++;
      checks++; if (dp !== e[0]) $display("FAIL mask_dp i=%0d got %b want %b", i, dp, e[0]); else passed++;
    end
    en = 1'b0;
    blank_mask = 8'h00;
    dp_mask    = 8'h00;
    @(negedge clk);
    @(negedge clk);
    $display("test_masks done");
  endtask

  task automatic test_en_drop_rst();
    en = 1'b1;
    for (int i = 1; i <= 28; i++) @(negedge clk);
    checks++; if (COM !== 8'hF7) $display("FAIL slot3_com got %h want f7", COM); else passed++;
    en = 1'b0;
    @(negedge clk);
    checks++; if (COM !== 8'hFF) $display("FAIL endrop_com got %h want ff", COM); else passed++;
    checks++; if (seg !== 7'h00) $display("FAIL endrop_seg got %h want 00", seg); else passed++;
    @(negedge clk);
    en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 4) begin
        load_valid = 1'b1;
        load_data  = 32'hAAAAAAAA;
      end
    end
    load_valid = 1'b0;
    checks++; if (load_ready !== 1'b0) $display("FAIL rst_pre_ready got %b want 0", load_ready); else passed++;
    checks++; if (COM !== 8'hFE) $display("FAIL rst_pre_com got %h want fe", COM); else passed++;
    #2 rst = 1'b1;
    #1;
    checks++; if (COM !== 8'hFF) $display("FAIL rst_async_com got %h want ff", COM); else passed++;
    @(negedge clk);
    checks++; if (load_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", load_ready); else passed++;
    rst = 1'b0;
    en  = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    en = 1'b1;
    for (int i = 1; i <= 3; i++) @(negedge clk);
    checks++; if (COM !== 8'hFE) $display("FAIL post_rst_com got %h want fe", COM); else passed++;
    checks++; if (seg !== 7'h3F) $display("FAIL post_rst_seg got %h want 3f", seg); else passed++;
    checks++; if (load_ready !== 1'b1) $display("FAIL post_rst_ready got %b want 1", load_ready); else passed++;
    en = 1'b0;
    @(negedge clk);
    $display("test_en_drop_rst done");
  endtask

  initial begin
    test_reset();
    test_scan_timing();
    test_frame_load();
    test_midframe_load();
    test_ignored_load();
    test_masks();
    test_en_drop_rst();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
